window_shift_reg: RTL and testbench

//  Downstream stage of the row-buffer controller. Captures the FIFO read stream gated by that

---
 rtl/sa_pkg.sv | 11 +
 rtl/en_align_pipe.sv | 30 +++
 rtl/window_shift_reg.sv | 74 +++++++
 tb/tb_window_shift_reg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared window geometry defaults and fill-state encoding
//   W_DATA  pixel width in bits
//   K       window dimension; TAPS = K*K pixels per window
//   CNT_W   width of the fill counter (counts 0..TAPS)
package sa_pkg;
    localparam int W_DATA = 8;
    localparam int K = 3;
    localparam int TAPS = K * K;
    localparam int CNT_W = $clog2(TAPS + 1);
    typedef enum logic {ST_EMPTY, ST_FILLING} fill_state_t;
endpackage

// File: rtl/en_align_pipe.sv
// en_align_pipe: DEPTH-stage 1-bit delay line aligning a read enable to FIFO read latency
//   clk    clock
//   rst_n  asynchronous active-low reset
//   clear  synchronous clear of all stages
//   din    enable in
//   dout   enable delayed by DEPTH cycles (combinational pass-through when DEPTH is 0)
module en_align_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic din,
    output logic dout
);
    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused;
            assign unused = &{1'b0, clk, rst_n, clear};
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0] pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pipe <= '0;
                else pipe <= clear ? '0 : DEPTH'({pipe, din});
            end
            assign dout = pipe[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/window_shift_reg.sv
// window_shift_reg: collects K*K streamed pixels into a flattened window with valid/ready output
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset
//   i_sr_enable     shift request, issued with the FIFO read
//   i_data          FIFO read data, valid RD_LATENCY cycles after i_sr_enable
//   i_clear         synchronous clear of partial fill and held window
//   i_out_ready     consumer ready
//   o_window        held window; tap i at [i*W_DATA +: W_DATA], tap 0 newest
//   o_window_valid  held window valid
//   o_fill_count    taps captured in current fill
//   o_overflow      sticky: a completed window was dropped because the output was held
module window_shift_reg #(
    parameter int W_DATA = sa_pkg::W_DATA,
    parameter int K = sa_pkg::K,
    parameter int RD_LATENCY = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_sr_enable,
    input  logic [W_DATA-1:0]           i_data,
    input  logic                        i_clear,
    input  logic                        i_out_ready,
    output logic [K*K*W_DATA-1:0]       o_window,
    output logic                        o_window_valid,
    output logic [$clog2(K*K+1)-1:0]    o_fill_count,
    output logic                        o_overflow
);
    import sa_pkg::*;
    localparam int N_TAPS = K * K;
    localparam int CW = $clog2(N_TAPS + 1);
    localparam int TW = N_TAPS * W_DATA;
    logic shift_en, complete, load, valid_nxt, overflow_nxt;
    fill_state_t state, state_nxt;
    logic [CW-1:0] count_nxt;
    logic [TW-1:0] taps, taps_nxt, shifted, window_nxt;
    en_align_pipe #(.DEPTH(RD_LATENCY)) u_align (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (i_clear),
        .din   (i_sr_enable),
        .dout  (shift_en)
    );
    // The completing shift's pixel goes straight into the output window, so the
    // window is built from the post-shift taps rather than the registered ones.
    always_comb begin
        shifted = {taps[TW-W_DATA-1:0], i_data};
        complete = shift_en & (o_fill_count == CW'(N_TAPS - 1));
        load = complete & (!o_window_valid | i_out_ready);
        taps_nxt = i_clear ? '0 : shift_en ? shifted : taps;
        count_nxt = i_clear | complete ? '0 :
                    shift_en ? (state == ST_EMPTY ? CW'(1) : o_fill_count + CW'(1)) : o_fill_count;
        state_nxt = i_clear | complete ? ST_EMPTY : shift_en ? ST_FILLING : state;
        window_nxt = load & !i_clear ? shifted : o_window;
        valid_nxt = !i_clear & (load | (o_window_valid & !i_out_ready));
        overflow_nxt = o_overflow | (complete & !load & !i_clear);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_EMPTY;
            taps <= '0;
            o_fill_count <= '0;
            o_window <= '0;
            o_window_valid <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            taps <= taps_nxt;
            o_fill_count <= count_nxt;
            o_window <= window_nxt;
            o_window_valid <= valid_nxt;
            o_overflow <= overflow_nxt;
        end
    end
endmodule

// File: tb/tb_window_shift_reg.sv
// tb_window_shift_reg: directed checks of window assembly, handshake, overflow, clear, reset and latency builds
module tb_window_shift_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic en1 = 1'b0, clr1 = 1'b0, rdy1 = 1'b0;
    logic [7:0] d1 = 8'h0;
    logic [71:0] win1;
    logic v1, ov1;
    logic [3:0] fc1;

    logic en6 = 1'b0, clr6 = 1'b0, rdy6 = 1'b0;
    logic [7:0] d6 = 8'h0;
    logic [71:0] win0, win2;
    logic v0, ov0, v2, ov2;
    logic [3:0] fc0, fc2;

    window_shift_reg #(.W_DATA(8), .K(3), .RD_LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sr_enable(en1), .i_data(d1), .i_clear(clr1),
        .i_out_ready(rdy1), .o_window(win1), .o_window_valid(v1), .o_fill_count(fc1),
        .o_overflow(ov1));
    window_shift_reg #(.W_DATA(8), .K(3), .RD_LATENCY(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sr_enable(en6), .i_data(d6), .i_clear(clr6),
        .i_out_ready(rdy6), .o_window(win0), .o_window_valid(v0), .o_fill_count(fc0),
        .o_overflow(ov0));
    window_shift_reg #(.W_DATA(8), .K(3), .RD_LATENCY(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sr_enable(en6), .i_data(d6), .i_clear(clr6),
        .i_out_ready(rdy6), .o_window(win2), .o_window_valid(v2), .o_fill_count(fc2),
        .o_overflow(ov2));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] seq_win(input int start);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(start + 8 - i);
        return w;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
    endtask

    // Enables on iterations 0..n-1; data for enable i is presented on iteration i+1.
    task automatic burst1(input int start, input int n, input int rdy_at, input int clr_at);
        for (int i = 0; i <= n; i++) begin
            en1 = (i < n);
            d1 = (i > 0) ? 8'(start + i - 1) : 8'h0;
            if (rdy_at >= 0) rdy1 = (i == rdy_at);
            if (clr_at >= 0) clr1 = (i == clr_at);
            step;
        end
        en1 = 1'b0;
        clr1 = 1'b0;
    endtask

    int e[9];
    int c;
    int j;
    logic [71:0] exp0, exp2;

    initial begin
        step;
        check("rst_valid", 72'(v1), 72'(0));
        check("rst_window", win1, 72'(0));
        check("rst_count", 72'(fc1), 72'(0));
        check("rst_overflow", 72'(ov1), 72'(0));
        step;
        rst_n = 1'b1;

        rdy1 = 1'b1;
        burst1(1, 9, -1, -1);
        check("t1_valid", 72'(v1), 72'(1));
        check("t1_window", win1, seq_win(1));
        check("t1_tap0", 72'(win1[7:0]), 72'(9));
        check("t1_tap8", 72'(win1[71:64]), 72'(1));
        check("t1_count", 72'(fc1), 72'(0));
        check("t1_overflow", 72'(ov1), 72'(0));
        step;
        check("t1_drain", 72'(v1), 72'(0));

        do_reset;
        rdy1 = 1'b0;
        burst1(1, 18, -1, -1);
        check("t2_valid", 72'(v1), 72'(1));
        check("t2_window_held", win1, seq_win(1));
        check("t2_overflow", 72'(ov1), 72'(1));
        rdy1 = 1'b1;
        step;
        check("t2_drain", 72'(v1), 72'(0));
        check("t2_overflow_sticky", 72'(ov1), 72'(1));

        do_reset;
        check("t3_overflow_cleared", 72'(ov1), 72'(0));
        rdy1 = 1'b0;
        burst1(1, 18, 18, -1);
        check("t3_valid", 72'(v1), 72'(1));
        check("t3_window", win1, seq_win(10));
        check("t3_overflow", 72'(ov1), 72'(0));
        rdy1 = 1'b1;
        step;
        check("t3_drain", 72'(v1), 72'(0));

        burst1(100, 5, -1, -1);
        check("t4_partial_count", 72'(fc1), 72'(5));
        rst_n = 1'b0;
        #2;
        check("t4_async_count", 72'(fc1), 72'(0));
        check("t4_async_valid", 72'(v1), 72'(0));
        step;
        rst_n = 1'b1;
        step;
        check("t4_no_partial", 72'(v1), 72'(0));
        burst1(20, 9, -1, -1);
        check("t4_valid", 72'(v1), 72'(1));
        check("t4_window", win1, seq_win(20));
        step;

        burst1(40, 4, -1, -1);
        check("t5_partial_count", 72'(fc1), 72'(4));
        clr1 = 1'b1;
        step;
        clr1 = 1'b0;
        check("t5_clear_count", 72'(fc1), 72'(0));
        burst1(50, 9, -1, -1);
        check("t5_valid", 72'(v1), 72'(1));
        check("t5_window", win1, seq_win(50));
        step;
        check("t5_drain", 72'(v1), 72'(0));
        burst1(60, 9, -1, 9);
        check("t5_clear_complete_valid", 72'(v1), 72'(0));
        check("t5_clear_complete_count", 72'(fc1), 72'(0));
        check("t5_clear_no_overflow", 72'(ov1), 72'(0));

        do_reset;
        c = 1;
        for (int k = 0; k < 9; k++) begin
            e[k] = c;
            c += 1 + int'($urandom_range(0, 2));
        end
        j = 0;
        for (int k = 0; k <= e[8] + 3; k++) begin
            en6 = (j < 9) && (e[j] == k);
            if (en6) j++;
            d6 = 8'(k);
            step;
        end
        en6 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp0[i*8 +: 8] = 8'(e[8 - i]);
            exp2[i*8 +: 8] = 8'(e[8 - i] + 2);
        end
        check("t6_l0_valid", 72'(v0), 72'(1));
        check("t6_l0_window", win0, exp0);
        check("t6_l0_count", 72'(fc0), 72'(0));
        check("t6_l0_overflow", 72'(ov0), 72'(0));
        check("t6_l2_valid", 72'(v2), 72'(1));
        check("t6_l2_window", win2, exp2);
        check("t6_l2_count", 72'(fc2), 72'(0));
        check("t6_l2_overflow", 72'(ov2), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
